// File: rtl/fuec_pkg.sv
// Shared FUEC(12,8) definitions used by the decoder interface and its consumers.
package fuec_pkg;

  localparam int FUEC_DATA_W  = 8;
  localparam int FUEC_NUM_POS = 8;
  localparam int FUEC_ADDR_W  = 8;

  typedef struct packed {
    logic [FUEC_ADDR_W-1:0]  addr;
    logic [FUEC_NUM_POS-1:0] pos;
  } fuec_evt_t;

endpackage

// File: rtl/fuec_evt_fifo.sv
// Small synchronous FIFO of (address, position) correction events.
module fuec_evt_fifo
  import fuec_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push,
  input  logic [ADDR_W-1:0]       push_addr,
  input  logic [FUEC_NUM_POS-1:0] push_pos,
  input  logic                    pop,
  output logic [ADDR_W-1:0]       head_addr,
  output logic [FUEC_NUM_POS-1:0] head_pos,
  output logic                    full,
  output logic                    empty
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;

  logic [ADDR_W-1:0]       mem_addr [DEPTH];
  logic [FUEC_NUM_POS-1:0] mem_pos  [DEPTH];
  logic [PTR_W-1:0]        wr_ptr;
  logic [PTR_W-1:0]        rd_ptr;
  logic                    do_push;
  logic                    do_pop;

  // The extra pointer bit separates full (MSBs differ) from empty (all equal).
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr == {~rd_ptr[PTR_W-1], rd_ptr[IDX_W-1:0]});

  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // Gating by empty makes the head read as zero without resetting the storage.
  assign head_addr = empty ? '0 : mem_addr[rd_ptr[IDX_W-1:0]];
  assign head_pos  = empty ? '0 : mem_pos[rd_ptr[IDX_W-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  // NOTE: storage is deliberately left out of reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_addr[wr_ptr[IDX_W-1:0]] <= push_addr;
      mem_pos[wr_ptr[IDX_W-1:0]]  <= push_pos;
    end
  end

endmodule

// File: rtl/fuec_err_monitor.sv
// Registered consumer of FUEC decoder output: forwards corrected bytes and
// tracks per-bit correction counters plus an event queue for weak-cell hunting.
module fuec_err_monitor
  import fuec_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int CNT_W     = 8,
  parameter int EVT_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [ADDR_W-1:0]       in_addr,
  input  logic [FUEC_DATA_W-1:0]  in_data,
  input  logic [FUEC_NUM_POS-1:0] in_pos_error,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [ADDR_W-1:0]       out_addr,
  output logic [FUEC_DATA_W-1:0]  out_data,
  output logic                    out_corr,
  output logic                    evt_valid,
  input  logic                    evt_ready,
  output logic [ADDR_W-1:0]       evt_addr,
  output logic [FUEC_NUM_POS-1:0] evt_pos,
  output logic                    evt_overflow,
  input  logic [2:0]              cnt_sel,
  output logic [CNT_W-1:0]        cnt_value,
  input  logic                    clr
);

  logic             accept;
  logic             push_req;
  logic             pop_req;
  logic             fifo_full;
  logic             fifo_empty;
  logic             drop;
  logic [CNT_W-1:0] cnt [FUEC_NUM_POS];

  assign in_ready = ~out_valid | out_ready;
  assign accept   = in_valid & in_ready;
  assign push_req = accept & (|in_pos_error);
  assign pop_req  = evt_ready & evt_valid;
  // A simultaneous pop frees a slot, so a full queue only drops without one.
  assign drop     = push_req & fifo_full & ~pop_req;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_addr  <= '0;
      out_data  <= '0;
      out_corr  <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_addr  <= in_addr;
      out_data  <= in_data;
      out_corr  <= |in_pos_error;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evt_overflow <= 1'b0;
    end else if (clr) begin
      evt_overflow <= 1'b0;
    end else if (drop) begin
      evt_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FUEC_NUM_POS; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < FUEC_NUM_POS; i++) begin
        if (clr) begin
          cnt[i] <= '0;
        end else if (accept && in_pos_error[i] && cnt[i] != '1) begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  assign cnt_value = cnt[cnt_sel];
  assign evt_valid = ~fifo_empty;

  fuec_evt_fifo #(
    .ADDR_W (ADDR_W),
    .DEPTH  (EVT_DEPTH)
  ) u_evt_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_req),
    .push_addr (in_addr),
    .push_pos  (in_pos_error),
    .pop       (pop_req),
    .head_addr (evt_addr),
    .head_pos  (evt_pos),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule

// File: tb/tb_fuec_err_monitor.sv
// Directed self-checking bench for fuec_err_monitor with hand-computed expectations.
module tb_fuec_err_monitor;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_addr;
  logic [7:0] in_data;
  logic [7:0] in_pos_error;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_addr;
  logic [7:0] out_data;
  logic       out_corr;
  logic       evt_valid;
  logic       evt_ready;
  logic [7:0] evt_addr;
  logic [7:0] evt_pos;
  logic       evt_overflow;
  logic [2:0] cnt_sel;
  logic [7:0] cnt_value;
  logic       clr;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fuec_err_monitor #(
    .ADDR_W    (8),
    .CNT_W     (8),
    .EVT_DEPTH (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_addr      (in_addr),
    .in_data      (in_data),
    .in_pos_error (in_pos_error),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_addr     (out_addr),
    .out_data     (out_data),
    .out_corr     (out_corr),
    .evt_valid    (evt_valid),
    .evt_ready    (evt_ready),
    .evt_addr     (evt_addr),
    .evt_pos      (evt_pos),
    .evt_overflow (evt_overflow),
    .cnt_sel      (cnt_sel),
    .cnt_value    (cnt_value),
    .clr          (clr)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] a, input logic [7:0] d, input logic [7:0] p);
    in_valid     = v;
    in_addr      = a;
    in_data      = d;
    in_pos_error = p;
  endtask

  task automatic read_cnt(input string tag, input logic [2:0] sel, input logic [7:0] exp);
    cnt_sel = sel;
    #1;
    check(tag, 32'(cnt_value), 32'(exp));
  endtask

  initial begin
    rst_n     = 1'b0;
    drive(1'b0, 8'h00, 8'h00, 8'h00);
    out_ready = 1'b1;
    evt_ready = 1'b0;
    cnt_sel   = 3'd0;
    clr       = 1'b0;
    #3;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_evt_valid", 32'(evt_valid), 32'd0);
    check("rst_out_data",  32'(out_data),  32'd0);
    check("rst_evt_ovf",   32'(evt_overflow), 32'd0);
    check("rst_evt_addr",  32'(evt_addr),  32'd0);
    step();
    rst_n = 1'b1;
    step();

    // Clean stream: no corrections, no events
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 8'(i), 8'(8'h30 + 7 * i), 8'h00);
      step();
      check("clean_valid", 32'(out_valid), 32'd1);
      check("clean_data",  32'(out_data),  32'(8'(8'h30 + 7 * i)));
      check("clean_addr",  32'(out_addr),  32'(i));
      check("clean_corr",  32'(out_corr),  32'd0);
      check("clean_evt",   32'(evt_valid), 32'd0);
    end
    drive(1'b0, 8'h00, 8'h00, 8'h00);
    step();
    check("clean_idle", 32'(out_valid), 32'd0);
    for (int s = 0; s < 8; s++) read_cnt("clean_cnt", 3'(s), 8'd0);

    // Single correction on bit 4
    drive(1'b1, 8'h2A, 8'hA5, 8'h10);
    step();
    drive(1'b0, 8'h00, 8'h00, 8'h00);
    check("corr_out_corr", 32'(out_corr),  32'd1);
    check("corr_out_data", 32'(out_data),  32'h0A5);
    check("corr_evt_vld",  32'(evt_valid), 32'd1);
    check("corr_evt_addr", 32'(evt_addr),  32'h02A);
    check("corr_evt_pos",  32'(evt_pos),   32'h010);
    read_cnt("corr_cnt4", 3'd4, 8'd1);
    read_cnt("corr_cnt3", 3'd3, 8'd0);
    evt_ready = 1'b1;
    step();
    evt_ready = 1'b0;
    check("corr_evt_popped", 32'(evt_valid), 32'd0);

    // Back-pressure: second word must be held, then both delivered in order
    out_ready = 1'b0;
    drive(1'b1, 8'h01, 8'h11, 8'h00);
    step();
    check("bp_first_valid", 32'(out_valid), 32'd1);
    check("bp_first_data",  32'(out_data),  32'h011);
    check("bp_in_ready",    32'(in_ready),  32'd0);
    drive(1'b1, 8'h02, 8'h22, 8'h00);
    step();
    check("bp_held_data",   32'(out_data),  32'h011);
    check("bp_still_stall", 32'(in_ready),  32'd0);
    out_ready = 1'b1;
    #1;
    check("bp_ready_again", 32'(in_ready),  32'd1);
    step();
    drive(1'b0, 8'h00, 8'h00, 8'h00);
    check("bp_second_data", 32'(out_data),  32'h022);
    check("bp_second_addr", 32'(out_addr),  32'h002);
    check("bp_second_vld",  32'(out_valid), 32'd1);
    step();
    check("bp_drained",     32'(out_valid), 32'd0);

    // Overflow: five events into a four-deep queue with no pops
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 8'(8'h40 + i), 8'(8'hC0 + i), 8'(8'h02 << i));
      step();
    end
    drive(1'b0, 8'h00, 8'h00, 8'h00);
    check("ovf_flag",      32'(evt_overflow), 32'd1);
    check("ovf_data_fwd",  32'(out_data),     32'h0C4);
    check("ovf_head_addr", 32'(evt_addr),     32'h040);
    check("ovf_head_pos",  32'(evt_pos),      32'h002);
    read_cnt("ovf_cnt4", 3'd4, 8'd2);
    read_cnt("ovf_cnt5", 3'd5, 8'd1);

    // Clear, then push and pop together while full
    clr = 1'b1;
    step();
    clr = 1'b0;
    check("clr_ovf", 32'(evt_overflow), 32'd0);
    read_cnt("clr_cnt4", 3'd4, 8'd0);
    check("clr_keeps_fifo", 32'(evt_addr), 32'h040);
    drive(1'b1, 8'h50, 8'h77, 8'h80);
    evt_ready = 1'b1;
    step();
    drive(1'b0, 8'h00, 8'h00, 8'h00);
    check("pp_full_ovf",  32'(evt_overflow), 32'd0);
    check("pp_full_head", 32'(evt_addr),     32'h041);
    step();
    check("pp_head2", 32'(evt_addr), 32'h042);
    step();
    check("pp_head3", 32'(evt_addr), 32'h043);
    step();
    check("pp_head4_addr", 32'(evt_addr), 32'h050);
    check("pp_head4_pos",  32'(evt_pos),  32'h080);
    step();
    check("pp_count4_empty", 32'(evt_valid), 32'd0);

    // Push with pop requested on an empty queue: the new entry becomes head
    drive(1'b1, 8'h60, 8'h66, 8'h02);
    step();
    drive(1'b0, 8'h00, 8'h00, 8'h00);
    check("pe_valid", 32'(evt_valid), 32'd1);
    check("pe_addr",  32'(evt_addr),  32'h060);
    step();
    evt_ready = 1'b0;
    check("pe_popped", 32'(evt_valid), 32'd0);

    // Saturation on bit 0
    for (int i = 0; i < 300; i++) begin
      drive(1'b1, 8'h70, 8'(i), 8'h01);
      step();
    end
    drive(1'b0, 8'h00, 8'h00, 8'h00);
    read_cnt("sat_cnt0", 3'd0, 8'd255);
    read_cnt("sat_cnt1", 3'd1, 8'd1);
    check("sat_ovf", 32'(evt_overflow), 32'd1);
    check("sat_data", 32'(out_data), 32'h02B);
    drive(1'b1, 8'h71, 8'h99, 8'h01);
    clr       = 1'b1;
    evt_ready = 1'b1;
    step();
    drive(1'b0, 8'h00, 8'h00, 8'h00);
    clr       = 1'b0;
    evt_ready = 1'b0;
    read_cnt("clr_win_cnt0", 3'd0, 8'd0);
    check("clr_win_ovf", 32'(evt_overflow), 32'd0);
    check("clr_win_data", 32'(out_data), 32'h099);

    // Drain to two entries, add a third correction, then reset mid-stream
    evt_ready = 1'b1;
    step();
    step();
    evt_ready = 1'b0;
    drive(1'b1, 8'h80, 8'h88, 8'h08);
    step();
    drive(1'b0, 8'h00, 8'h00, 8'h00);
    out_ready = 1'b0;
    check("pre_rst_out_valid", 32'(out_valid), 32'd1);
    check("pre_rst_evt_valid", 32'(evt_valid), 32'd1);
    read_cnt("pre_rst_cnt3", 3'd3, 8'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_evt_valid", 32'(evt_valid), 32'd0);
    check("arst_cnt3",      32'(cnt_value), 32'd0);
    check("arst_out_data",  32'(out_data),  32'd0);
    check("arst_in_ready",  32'(in_ready),  32'd1);
    step();
    rst_n = 1'b1;
    step();
    check("post_rst_evt", 32'(evt_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
